// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between CPU and loader, guards against loader starvation and routes read data back
module mem_arbiter #(
  parameter int READ_LAT = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [14:0] ldr_addr,
  input  logic [15:0] ldr_wdata,
  output logic        ldr_gnt,
  output logic        ldr_rvalid,
  output logic [15:0] ldr_rdata,
  output logic        ldr_err,
  output logic [14:0] mem_address,
  output logic [15:0] mem_in,
  output logic        mem_load,
  input  logic [15:0] mem_out
);
  logic [3:0] wait_cnt;
  logic [1:0] tag [READ_LAT];
  logic       force_ldr;
  logic       sel_we;
  // Arbitration, memory mux and write guard; the loader only wins over a requesting CPU once it has waited MAX_WAIT cycles
  always_comb begin
    force_ldr   = wait_cnt == 4'(MAX_WAIT);
    ldr_gnt     = reset_n & ldr_req & (~cpu_req | force_ldr);
    cpu_gnt     = reset_n & cpu_req & ~(ldr_req & force_ldr);
    mem_address = ldr_gnt ? ldr_addr : cpu_addr;
    mem_in      = ldr_gnt ? ldr_wdata : cpu_wdata;
    sel_we      = ldr_gnt ? ldr_we : cpu_we;
    mem_load    = (cpu_gnt | ldr_gnt) & sel_we & (mem_address < 15'h6000);
  end
  // Read data steering from the tag at the output stage; tag bit 1 = valid, bit 0 = loader
  always_comb begin
    cpu_rvalid = tag[READ_LAT-1][1] & ~tag[READ_LAT-1][0];
    ldr_rvalid = tag[READ_LAT-1][1] & tag[READ_LAT-1][0];
    cpu_rdata  = cpu_rvalid ? mem_out : 16'h0;
    ldr_rdata  = ldr_rvalid ? mem_out : 16'h0;
  end
  // Starvation counter: counts denied loader cycles, cleared on loader grant or idle loader
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) wait_cnt <= '0;
    else if (!ldr_req || ldr_gnt) wait_cnt <= '0;
    else if (!force_ldr) wait_cnt <= wait_cnt + 4'd1;
  // Write-to-keyboard-region error pulses, one cycle after the grant edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cpu_err <= 1'b0;
      ldr_err <= 1'b0;
    end else begin
      cpu_err <= cpu_gnt & cpu_we & (cpu_addr >= 15'h6000);
      ldr_err <= ldr_gnt & ldr_we & (ldr_addr >= 15'h6000);
    end
  // Read tag pipeline matching the memory read latency; writes and idle cycles insert invalid tags
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < READ_LAT; i++) tag[i] <= 2'b00;
    end else begin
      tag[0] <= {(cpu_gnt | ldr_gnt) & ~sel_we, ldr_gnt};
      for (int i = 1; i < READ_LAT; i++) tag[i] <= tag[i-1];
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a latency-matched memory model
module tb_mem_arbiter;
  localparam int RL = 3;
  localparam int MW = 4;
  logic        clk;
  logic        reset_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_err;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        ldr_req, ldr_we, ldr_gnt, ldr_rvalid, ldr_err;
  logic [14:0] ldr_addr;
  logic [15:0] ldr_wdata, ldr_rdata;
  logic [14:0] mem_address;
  logic [15:0] mem_in, mem_out;
  logic        mem_load;
  int          errors;
  int          checks;
  logic [15:0] mem [0:32767];
  logic [15:0] rd_pipe [RL];

  mem_arbiter #(.READ_LAT(RL), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata), .ldr_err(ldr_err),
    .mem_address(mem_address), .mem_in(mem_in), .mem_load(mem_load), .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: synchronous write, read data appears RL cycles after the address cycle
  always @(posedge clk) begin
    if (mem_load) mem[mem_address] <= mem_in;
    rd_pipe[0] <= mem[mem_address];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_out = rd_pipe[RL-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_rv(input string tag, input logic cv, input logic [15:0] cd, input logic lv, input logic [15:0] ld);
    chk({tag, ".cpu_rvalid"}, cpu_rvalid, cv);
    chk({tag, ".cpu_rdata"}, cpu_rdata, cd);
    chk({tag, ".ldr_rvalid"}, ldr_rvalid, lv);
    chk({tag, ".ldr_rdata"}, ldr_rdata, ld);
  endtask

  task automatic step(input logic cr, input logic cw, input logic [14:0] ca, input logic [15:0] cd,
                      input logic lr, input logic lw, input logic [14:0] la, input logic [15:0] ld);
    @(negedge clk);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 15'h0, 16'h0, 0, 0, 15'h0, 16'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234; cpu_wdata = 16'h0;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 15'h0042; ldr_wdata = 16'h0;
    #12;
    chk("rst.cpu_gnt", cpu_gnt, 0);
    chk("rst.ldr_gnt", ldr_gnt, 0);
    chk("rst.mem_load", mem_load, 0);
    chk("rst.mem_address", mem_address, 15'h1234);
    chk("rst.cpu_err", cpu_err, 0);
    chk("rst.ldr_err", ldr_err, 0);
    chk_rv("rst", 0, 16'h0, 0, 16'h0);
    @(negedge clk);
    reset_n = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0;

    step(1, 1, 15'h0001, 16'h1111, 0, 0, 15'h0, 16'h0);
    chk("pre1.mem_load", mem_load, 1);
    step(1, 1, 15'h0002, 16'h2222, 0, 0, 15'h0, 16'h0);
    chk("pre2.mem_load", mem_load, 1);

    step(1, 1, 15'h4000, 16'h4567, 0, 0, 15'h0, 16'h0);
    chk("wr.cpu_gnt", cpu_gnt, 1);
    chk("wr.ldr_gnt", ldr_gnt, 0);
    chk("wr.mem_load", mem_load, 1);
    chk("wr.mem_address", mem_address, 15'h4000);
    chk("wr.mem_in", mem_in, 16'h4567);
    step(1, 0, 15'h4000, 16'h0, 0, 0, 15'h0, 16'h0);
    chk("rd.cpu_gnt", cpu_gnt, 1);
    chk("rd.mem_load", mem_load, 0);
    idle();
    chk_rv("rd+1", 0, 16'h0, 0, 16'h0);
    idle();
    chk_rv("rd+2", 0, 16'h0, 0, 16'h0);
    idle();
    chk_rv("rd+3", 1, 16'h4567, 0, 16'h0);
    idle();
    chk_rv("rd+4", 0, 16'h0, 0, 16'h0);

    for (int i = 0; i < 8; i++) begin
      step(1, 0, 15'h0001, 16'h0, 1, 0, 15'h0002, 16'h0);
      chk($sformatf("cont%0d.cpu_gnt", i), cpu_gnt, i != 4);
      chk($sformatf("cont%0d.ldr_gnt", i), ldr_gnt, i == 4);
      chk($sformatf("cont%0d.mem_address", i), mem_address, (i == 4) ? 15'h0002 : 15'h0001);
      if (i < 3) chk_rv($sformatf("cont%0d", i), 0, 16'h0, 0, 16'h0);
      else if (i == 7) chk_rv($sformatf("cont%0d", i), 0, 16'h0, 1, 16'h2222);
      else chk_rv($sformatf("cont%0d", i), 1, 16'h1111, 0, 16'h0);
    end
    idle();
    idle();
    idle();

    step(0, 0, 15'h0, 16'h0, 1, 1, 15'h6000, 16'h1234);
    chk("g6000.ldr_gnt", ldr_gnt, 1);
    chk("g6000.cpu_gnt", cpu_gnt, 0);
    chk("g6000.mem_load", mem_load, 0);
    chk("g6000.mem_address", mem_address, 15'h6000);
    idle();
    chk("g6000+1.ldr_err", ldr_err, 1);
    chk("g6000+1.cpu_err", cpu_err, 0);
    idle();
    chk("g6000+2.ldr_err", ldr_err, 0);
    step(0, 0, 15'h0, 16'h0, 1, 1, 15'h5FFF, 16'hBEEF);
    chk("g5fff.mem_load", mem_load, 1);
    chk("g5fff.mem_address", mem_address, 15'h5FFF);
    chk("g5fff.mem_in", mem_in, 16'hBEEF);
    idle();
    chk("g5fff+1.ldr_err", ldr_err, 0);
    step(1, 1, 15'h7FFF, 16'h5555, 0, 0, 15'h0, 16'h0);
    chk("g7fff.cpu_gnt", cpu_gnt, 1);
    chk("g7fff.mem_load", mem_load, 0);
    idle();
    chk("g7fff+1.cpu_err", cpu_err, 1);
    chk("g7fff+1.ldr_err", ldr_err, 0);
    idle();
    chk("g7fff+2.cpu_err", cpu_err, 0);
    step(0, 0, 15'h0, 16'h0, 1, 0, 15'h5FFF, 16'h0);
    chk("lrd.ldr_gnt", ldr_gnt, 1);
    idle();
    chk_rv("lrd+1", 0, 16'h0, 0, 16'h0);
    idle();
    chk_rv("lrd+2", 0, 16'h0, 0, 16'h0);
    idle();
    chk_rv("lrd+3", 0, 16'h0, 1, 16'hBEEF);

    step(1, 0, 15'h0001, 16'h0, 0, 0, 15'h0, 16'h0);
    chk("mix0.cpu_gnt", cpu_gnt, 1);
    step(0, 0, 15'h0, 16'h0, 1, 0, 15'h0002, 16'h0);
    chk("mix1.ldr_gnt", ldr_gnt, 1);
    chk("mix1.mem_address", mem_address, 15'h0002);
    step(1, 1, 15'h0003, 16'h3333, 0, 0, 15'h0, 16'h0);
    chk("mix2.cpu_gnt", cpu_gnt, 1);
    chk("mix2.mem_load", mem_load, 1);
    idle();
    chk_rv("mix+3", 1, 16'h1111, 0, 16'h0);
    idle();
    chk_rv("mix+4", 0, 16'h0, 1, 16'h2222);
    idle();
    chk_rv("mix+5", 0, 16'h0, 0, 16'h0);

    step(1, 0, 15'h0001, 16'h0, 0, 0, 15'h0, 16'h0);
    chk("rrd.cpu_gnt", cpu_gnt, 1);
    @(negedge clk);
    reset_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0777; cpu_wdata = 16'h9999;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 15'h0100;
    #1;
    chk("rrd.rst.cpu_gnt", cpu_gnt, 0);
    chk("rrd.rst.ldr_gnt", ldr_gnt, 0);
    chk("rrd.rst.mem_load", mem_load, 0);
    chk("rrd.rst.mem_address", mem_address, 15'h0777);
    chk_rv("rrd.rst", 0, 16'h0, 0, 16'h0);
    @(negedge clk);
    reset_n = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0;
    #1;
    chk_rv("rrd.rel0", 0, 16'h0, 0, 16'h0);
    for (int i = 1; i < 4; i++) begin
      idle();
      chk_rv($sformatf("rrd.rel%0d", i), 0, 16'h0, 0, 16'h0);
    end

    for (int i = 0; i < 10; i++) begin
      idle();
      chk($sformatf("idle%0d.cpu_gnt", i), cpu_gnt, 0);
      chk($sformatf("idle%0d.ldr_gnt", i), ldr_gnt, 0);
      chk($sformatf("idle%0d.mem_load", i), mem_load, 0);
      chk($sformatf("idle%0d.rvalid", i), {cpu_rvalid, ldr_rvalid}, 0);
      chk($sformatf("idle%0d.err", i), {cpu_err, ldr_err}, 0);
    end

    for (int i = 0; i < 5; i++) begin
      step(1, 0, 15'h0001, 16'h0, 1, 0, 15'h0002, 16'h0);
      chk($sformatf("cont2_%0d.ldr_gnt", i), ldr_gnt, i == 4);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter placed in front of the `memory` block (RAM 0x0000–0x3FFF, display registers 0x4000–0x4003, keyboard 0x6000). It shares the single memory port between the CPU and a program/data loader. It issues at most one access per cycle, prevents loader starvation and routes read data back to the port that issued the read. It also blocks writes to the read-only keyboard region.

## Interface
- READ_LAT, 1, cycles from the grant cycle to the cycle in which `mem_out` holds the read data; legal range 1–3.
- MAX_WAIT, 4, consecutive denied loader cycles before the loader is forced to win; legal range 1–15.

- clk  in  1  system clock; everything is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write (1) or read (0).
- cpu_addr  in  15  CPU word address.
- cpu_wdata  in  16  CPU write data.
- cpu_gnt  out  1  CPU access accepted at the coming edge (combinational).
- cpu_rvalid  out  1  `cpu_rdata` valid this cycle.
- cpu_rdata  out  16  read data for the CPU.
- cpu_err  out  1  one-cycle pulse: the granted CPU write targeted an address ≥ 0x6000.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_rvalid, ldr_rdata, ldr_err: loader port; same widths and meaning as the CPU port.
- mem_address  out  15  address to memory.
- mem_in  out  16  write data to memory.
- mem_load  out  1  write enable to memory.
- mem_out  in  16  read data from memory.

## Operation
- Requests are level signals. A requester holds req, we, addr and wdata stable until it sees gnt high. The transfer completes at the edge that ends the gnt cycle.
- Default priority is the CPU. If both ports request, the CPU is granted, unless the starvation rule below applies.
- Starvation counter `wait_cnt` (4 bits):
  - Increments on each edge where `ldr_req=1` and `ldr_gnt=0`.
  - Clears on a loader grant, or when `ldr_req=0`.
  - When `wait_cnt == MAX_WAIT`, the loader wins the next arbitration even if `cpu_req=1`.
- Memory mux:
  - The granted port drives mem_address and mem_in.
  - With no grant, the mux selects the CPU and `mem_load=0`.
- `mem_load = gnt_any & we & (addr < 0x6000)`.
  - A granted write with addr ≥ 0x6000 is still granted and consumed, but not written.
  - The owning port's err is registered and pulses for one cycle after the grant edge.
- Read tagging: a granted read pushes a 2-bit tag {valid, port} into a READ_LAT-deep shift register; the pipeline advances every cycle.
  - When the tag reaches the output stage, the matching rvalid is asserted and that port's rdata = mem_out.
  - The non-matching rdata is 0.
- Writes push an invalid tag. Reads and writes may be back-to-back every cycle with no bubbles.

## Timing
- gnt is combinational from req, wait_cnt and reset_n; both gnt signals are 0 while reset_n=0.
- The read granted in cycle N has rvalid high in cycle N+READ_LAT, for exactly one cycle.
- Reset values:
  - wait_cnt=0, tag pipeline all invalid.
  - cpu_rvalid=ldr_rvalid=0, cpu_err=ldr_err=0, cpu_rdata=ldr_rdata=0.
  - mem_load=0, mem_address=cpu_addr.
- Reset asserted mid-operation discards all in-flight reads: no rvalid is produced for them after reset is released.
- Simultaneous events:
  - A loader forced win with `cpu_req=1`: the CPU holds its request and is granted the next cycle if the loader drops its request or wait_cnt has cleared.
  - Counter saturation: wait_cnt never exceeds MAX_WAIT.
- Address 0x5FFF is writable; 0x6000 and every address up to 0x7FFF are write-blocked. Reads anywhere are passed through.

## Test plan
- CPU alone, READ_LAT=1:
  - Write 0x4567 to 0x4000: cpu_gnt=1, mem_load=1.
  - Read 0x4000 in the next cycle: cpu_rvalid=1 one cycle later with cpu_rdata=0x4567, ldr_rvalid=0.
- Contention, MAX_WAIT=4, both ports requesting reads continuously: the CPU is granted for 4 cycles, the loader on the 5th, then the CPU again. Each rvalid goes to the correct port with that port's data.
- Write guard:
  - Loader writes 0x1234 to 0x6000: ldr_gnt=1, mem_load=0, ldr_err pulses one cycle later.
  - Loader writes to 0x5FFF: mem_load=1, no err.
- Back-to-back mixed traffic, READ_LAT=3: CPU read 0x0001, loader read 0x0002, CPU write 0x0003 in consecutive cycles. Expect cpu_rvalid at N+3 and ldr_rvalid at N+4, with data 0x1111 and 0x2222 preloaded; no rvalid at N+5.
- Reset mid-read, READ_LAT=2: pull reset_n low one cycle after a CPU read grant. All outputs go to reset values immediately and no rvalid appears after release.
- Idle: both req=0 for 10 cycles. Both gnt stay 0, mem_load=0, wait_cnt=0, no rvalid and no err.
